// File: rtl/p2s_pkg.sv
// Shared definitions for the p2s transmit arbiter: widths, FSM encoding and index helpers.
package p2s_pkg;

  localparam int unsigned SER_W = 16;
  localparam int unsigned LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // (a + b) mod n, used for round-robin pointer arithmetic
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker
  import p2s_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!o_valid && i_req[wrap_add(32'(i_ptr), i, N_REQ)]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(wrap_add(32'(i_ptr), i, N_REQ));
      end
    end
  end

endmodule

// File: rtl/p2s_tx_arbiter.sv
// Round-robin arbiter sharing one p2s serializer: one frame per grant, ack on completion,
// watchdog abort, and a fixed idle gap between frames.
module p2s_tx_arbiter
  import p2s_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned WDOG_CYCLES = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [SER_W*N_REQ-1:0]     i_req_data,
  input  logic [LEN_W*N_REQ-1:0]     i_req_len,
  output logic [N_REQ-1:0]           o_ack,
  output logic                       o_err,
  output logic                       o_busy,
  output logic [$clog2(N_REQ)-1:0]   o_grant_id,
  output logic [SER_W-1:0]           o_ser_data,
  output logic [LEN_W-1:0]           o_ser_len,
  output logic                       o_ser_enable,
  input  logic                       i_ser_done
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

  state_e              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_grant_id;
  logic [SER_W-1:0]    r_ser_data;
  logic [LEN_W-1:0]    r_ser_len;
  logic                r_ser_enable;
  logic [N_REQ-1:0]    r_ack;
  logic                r_err;
  logic [WDOG_W-1:0]   r_wdog;
  logic [GAP_W-1:0]    r_gap;

  logic                w_valid;
  logic [IDX_W-1:0]    w_idx;
  logic [SER_W-1:0]    w_data;
  logic [LEN_W-1:0]    w_len;
  logic [IDX_W-1:0]    w_ptr_next;
  logic [N_REQ-1:0]    w_win_oh;
  logic [N_REQ-1:0]    w_grant_oh;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_data     = i_req_data[SER_W*int'(w_idx) +: SER_W];
  assign w_len      = i_req_len[LEN_W*int'(w_idx) +: LEN_W];
  assign w_ptr_next = IDX_W'(wrap_add(32'(w_idx), 1, N_REQ));
  assign w_win_oh   = N_REQ'(1) << w_idx;
  assign w_grant_oh = N_REQ'(1) << r_grant_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_grant_id   <= '0;
      r_ser_data   <= '0;
      r_ser_len    <= '0;
      r_ser_enable <= 1'b0;
      r_ack        <= '0;
      r_err        <= 1'b0;
      r_wdog       <= '0;
      r_gap        <= '0;
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_ser_data <= w_data;
            r_ser_len  <= w_len;
            r_grant_id <= w_idx;
            r_ptr      <= w_ptr_next;
            // A zero-length frame would never complete in the p2s; acknowledge and skip it.
            if (w_len == '0) begin
              r_ack <= w_win_oh;
            end else begin
              r_ser_enable <= 1'b1;
              r_state      <= ST_SEND;
              r_wdog       <= '0;
            end
          end
        end
        ST_SEND: begin
          if (i_ser_done) begin
            r_ser_enable <= 1'b0;
            r_ack        <= w_grant_oh;
            r_state      <= ST_GAP;
            r_gap        <= '0;
          end else if (r_wdog == WDOG_W'(WDOG_CYCLES - 1)) begin
            r_ser_enable <= 1'b0;
            r_ack        <= w_grant_oh;
            r_err        <= 1'b1;
            r_state      <= ST_GAP;
            r_gap        <= '0;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ack        = r_ack;
  assign o_err        = r_err;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_grant_id   = r_grant_id;
  assign o_ser_data   = r_ser_data;
  assign o_ser_len    = r_ser_len;
  assign o_ser_enable = r_ser_enable;

endmodule

// File: tb/tb_p2s_tx_arbiter.sv
// Bench for p2s_tx_arbiter with a behavioural p2s serializer behind it.
module tb_p2s_tx_arbiter;

  localparam int N    = 4;
  localparam int GAP  = 2;
  localparam int WDOG = 20;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_w;
  logic [16*N-1:0] data_w;
  logic [4*N-1:0]  len_w;
  logic [N-1:0]    ack;
  logic            err;
  logic            busy;
  logic [1:0]      grant_id;
  logic [15:0]     ser_data;
  logic [3:0]      ser_len;
  logic            ser_enable;
  logic            ser_done;

  bit              pend [N];
  logic [15:0]     dat  [N];
  logic [3:0]      lenv [N];
  bit              disconnect;
  int              n_chk;
  int              n_pass;
  int              m_ptr;

  logic [4:0]      p_cnt;
  logic            p_line;

  p2s_tx_arbiter #(
    .N_REQ       (N),
    .GAP_CYCLES  (GAP),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req        (req_w),
    .i_req_data   (data_w),
    .i_req_len    (len_w),
    .o_ack        (ack),
    .o_err        (err),
    .o_busy       (busy),
    .o_grant_id   (grant_id),
    .o_ser_data   (ser_data),
    .o_ser_len    (ser_len),
    .o_ser_enable (ser_enable),
    .i_ser_done   (ser_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_w  = '0;
    data_w = '0;
    len_w  = '0;
    for (int i = 0; i < N; i++) begin
      req_w[i]          = pend[i];
      data_w[16*i +: 16] = dat[i];
      len_w[4*i +: 4]    = lenv[i];
    end
  end

  // Serializer: one bit per enabled cycle after the first, MSB first; done on the last bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_cnt  <= '0;
      p_line <= 1'b0;
    end else if (ser_enable) begin
      if (p_cnt < {1'b0, ser_len}) begin
        p_line <= ser_data[15 - int'(p_cnt)];
        p_cnt  <= p_cnt + 5'd1;
      end
    end else begin
      p_cnt  <= '0;
      p_line <= 1'b0;
    end
  end
  assign ser_done = !disconnect && ser_enable && (p_cnt != 0) && (p_cnt == {1'b0, ser_len});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic raise(input int j);
    pend[j] = 1'b1;
    dat[j]  = 16'($urandom);
    lenv[j] = 4'($urandom_range(1, 15));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    disconnect = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      dat[i]  = '0;
      lenv[i] = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
  endtask

  // Reference round-robin choice over the pending requests.
  function automatic int pick(input int ptr);
    for (int i = 0; i < N; i++) begin
      if (pend[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // keep: 0 drop req at ack, 1 hold it, 2 randomly re-raise with new data.
  task automatic check_frame(input int id, input bit gap_chk, input int keep, input bit scramble,
                             input bit others);
    logic [15:0] d;
    int          l;
    int          low;
    int          ecnt;
    logic [15:0] bits;
    d    = dat[id];
    l    = int'(lenv[id]);
    low  = 1;
    ecnt = 1;
    bits = '0;
    while (low < 200) begin
      @(negedge clk);
      if (ser_enable) break;
      low++;
    end
    chk("frame_start", 32'(ser_enable), 1);
    if (!ser_enable) return;
    if (gap_chk) chk("gap_len", low, GAP + 1);
    chk("grant_id", 32'(grant_id), id);
    chk("ser_data", 32'(ser_data), 32'(d));
    chk("ser_len", 32'(ser_len), l);
    chk("busy", 32'(busy), 1);
    if (scramble) begin
      dat[id]  = ~d;
      lenv[id] = 4'(l + 3);
      pend[id] = 1'b0;
    end
    if (others) begin
      for (int j = 0; j < N; j++) begin
        if (j != id && !pend[j] && ($urandom % 2 == 1)) raise(j);
      end
    end
    while (ecnt < 40) begin
      @(negedge clk);
      if (!ser_enable) break;
      ecnt++;
      bits = {bits[14:0], p_line};
    end
    chk("en_cycles", ecnt, l + 1);
    chk("line_bits", 32'(bits), 32'(d >> (16 - l)));
    chk("ack", 32'(ack), 32'(1) << id);
    chk("err", 32'(err), 0);
    if (keep == 0) pend[id] = 1'b0;
    else if (keep == 2) begin
      if ($urandom % 3 == 0) raise(id);
      else pend[id] = 1'b0;
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] data;
    logic [3:0]  len;
    int          exp_id;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    int id;
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    disconnect = 1'b0;
    vecs[0] = '{4'b0001, 16'hA000, 4'd4,  0};
    vecs[1] = '{4'b0100, 16'hC3F0, 4'd8,  2};
    vecs[2] = '{4'b1010, 16'hFFFF, 4'd15, 1};
    vecs[3] = '{4'b1000, 16'h8000, 4'd1,  3};
    vecs[4] = '{4'b0110, 16'h5A5A, 4'd12, 1};

    @(negedge clk);
    chk("reset_outputs", 32'({ack, err, busy, grant_id, ser_data, ser_len, ser_enable}), 0);

    // Single frames from reset: lowest set request wins, line carries the MSB-aligned bits.
    foreach (vecs[k]) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        if (vecs[k].mask[i]) begin
          pend[i] = 1'b1;
          dat[i]  = vecs[k].data;
          lenv[i] = vecs[k].len;
        end
      end
      check_frame(vecs[k].exp_id, 1'b0, 0, 1'b0, 1'b0);
    end

    // All requesters held: strict rotation with a fixed gap.
    do_reset();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      dat[i]  = 16'h2000 << i;
      lenv[i] = 4'd3;
    end
    for (int f = 0; f < 5; f++) check_frame(f % N, f > 0, 1, 1'b0, 1'b0);

    // Zero-length request is skipped with an ack, next requester follows.
    do_reset();
    pend[0] = 1'b1; dat[0] = 16'h1234; lenv[0] = 4'd0;
    pend[1] = 1'b1; dat[1] = 16'hE000; lenv[1] = 4'd3;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (ack != 0 || ser_enable) break;
    end
    chk("len0_ack", 32'(ack), 1);
    chk("len0_no_enable", 32'(ser_enable), 0);
    pend[0] = 1'b0;
    check_frame(1, 1'b0, 0, 1'b0, 1'b0);

    // Watchdog abort with the serializer never reporting done.
    do_reset();
    disconnect = 1'b1;
    pend[2] = 1'b1; dat[2] = 16'hF0F0; lenv[2] = 4'd4;
    n = 0;
    while (n < 20 && !ser_enable) begin
      @(negedge clk);
      n++;
    end
    n = 1;
    while (n < 100) begin
      @(negedge clk);
      if (!ser_enable) break;
      n++;
    end
    chk("wdog_cycles", n, WDOG);
    chk("wdog_err", 32'(err), 1);
    chk("wdog_ack", 32'(ack), 32'h4);
    pend[2] = 1'b0;
    disconnect = 1'b0;
    repeat (GAP) @(negedge clk);
    chk("wdog_idle", 32'(busy), 0);

    // Reset mid-frame, then the pointer must be back at requester 0.
    do_reset();
    pend[1] = 1'b1; dat[1] = 16'h9000; lenv[1] = 4'd6;
    n = 0;
    while (n < 20 && !ser_enable) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_outputs", 32'({ack, err, busy, grant_id, ser_data, ser_len, ser_enable}), 0);
    pend[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b1;
      dat[i]  = 16'h6000 + 16'(i);
      lenv[i] = 4'd5;
    end
    check_frame(0, 1'b0, 0, 1'b0, 1'b0);

    // Requester drops req and changes its word mid-frame.
    do_reset();
    pend[1] = 1'b1; dat[1] = 16'hB5C0; lenv[1] = 4'd10;
    check_frame(1, 1'b0, 0, 1'b1, 1'b0);

    // Randomized traffic against the round-robin reference.
    do_reset();
    raise($urandom_range(0, N - 1));
    for (int f = 0; f < 30; f++) begin
      id = pick(m_ptr);
      if (id < 0) begin
        chk("model_pending", 0, 1);
        break;
      end
      check_frame(id, f > 0, 2, 1'b0, 1'b1);
      m_ptr = (id + 1) % N;
      if (pick(m_ptr) < 0) raise($urandom_range(0, N - 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
